// File: rtl/interleaver_agen_pkg.sv
// Shared types and width helpers for the interleaver address generator.
//   state_e      : walk FSM states (IDLE, RUN)
//   calc_lpz     : bits of the row offset within one sweep, log2(P/Z)
//   calc_lp      : bits of one activation address, log2(P)
//   calc_cw      : bits of the walk cycle counter, log2(FO*P/Z)
//   calc_ncyc    : number of address sets in one complete walk
package interleaver_agen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int calc_lpz(input int p, input int z);
    return $clog2(p / z);
  endfunction

  function automatic int calc_lp(input int p);
    return $clog2(p);
  endfunction

  function automatic int calc_cw(input int fo, input int p, input int z);
    return $clog2(fo * p / z);
  endfunction

  function automatic int calc_ncyc(input int fo, input int p, input int z);
    return fo * p / z;
  endfunction

endpackage

// File: rtl/interleaver_agen_if.sv
// Stream bundle between the junction controller, the address generator and
// the activation memory read ports.
//   ld_*      : seed-row load handshake (one sweep row of Z seeds per beat)
//   start/dir/abort/busy/done/seeded : walk control and status
//   out_*     : address-set stream toward the activation memory
// master = controller/consumer side, slave = address generator.
interface interleaver_agen_if #(
  parameter int FO = 2,
  parameter int P  = 32,
  parameter int Z  = 8
);
  import interleaver_agen_pkg::*;

  localparam int LPZ = calc_lpz(P, Z);
  localparam int LP  = calc_lp(P);
  localparam int CW  = calc_cw(FO, P, Z);

  logic              ld_valid;
  logic              ld_ready;
  logic [LPZ*Z-1:0]  ld_data;
  logic              seeded;
  logic              start;
  logic              dir;
  logic              abort;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [LP*Z-1:0]   out_index;
  logic [CW-1:0]     out_cycle;
  logic              out_last;
  logic              done;

  modport master (
    output ld_valid, ld_data, start, dir, abort, out_ready,
    input  ld_ready, seeded, busy, out_valid, out_index, out_cycle, out_last, done
  );

  modport slave (
    input  ld_valid, ld_data, start, dir, abort, out_ready,
    output ld_ready, seeded, busy, out_valid, out_index, out_cycle, out_last, done
  );

endinterface

// File: rtl/interleaver_agen_lane.sv
// One address lane: rotates a seed by the row offset inside its sweep and
// places the result in lane IDX's stripe of the activation memory.
//   seed    : seed for this lane in the active sweep (LPZ bits)
//   row_off : row offset within the sweep (LPZ bits)
//   addr    : ((seed + row_off) mod P/Z) * Z + IDX  (LP bits)
module interleaver_agen_lane #(
  parameter int LPZ = 2,
  parameter int LP  = 5,
  parameter int Z   = 8,
  parameter int IDX = 0
) (
  input  logic [LPZ-1:0] seed,
  input  logic [LPZ-1:0] row_off,
  output logic [LP-1:0]  addr
);

  localparam logic [LP-1:0] Z_W   = LP'(Z);
  localparam logic [LP-1:0] IDX_W = LP'(IDX);

  logic [LPZ-1:0] rot;

  // The LPZ-bit sum wraps naturally, giving the mod P/Z rotation.
  assign rot  = seed + row_off;
  assign addr = LP'(rot) * Z_W + IDX_W;

endmodule

// File: rtl/interleaver_agen.sv
// Seed-programmable interleaver address generator for one junction.
//   clk   : clock
//   reset : asynchronous, active-high; clears seeds as well as walk state
//   bus   : interleaver_agen_if.slave (seed load, walk control, address stream)
// Seeds are loaded row by row while idle; a start pulse then walks all
// FO*P/Z cycles forward or backward, emitting Z addresses per cycle through a
// registered valid/ready output stage.
module interleaver_agen
  import interleaver_agen_pkg::*;
#(
  parameter int FO = 2,
  parameter int P  = 32,
  parameter int Z  = 8
) (
  input  logic                clk,
  input  logic                reset,
  interleaver_agen_if.slave   bus
);

  localparam int LPZ  = calc_lpz(P, Z);
  localparam int LP   = calc_lp(P);
  localparam int CW   = calc_cw(FO, P, Z);
  localparam int NCYC = calc_ncyc(FO, P, Z);
  localparam int PW   = (FO > 1) ? $clog2(FO) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(NCYC - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(FO - 1);

  state_e            state_q, state_d;
  logic [LPZ*Z-1:0]  seed_q [FO];
  logic [LPZ*Z-1:0]  seed_d [FO];
  logic [PW-1:0]     ld_ptr_q, ld_ptr_d;
  logic              seeded_q, seeded_d;
  logic              dir_q, dir_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              done_q, done_d;
  logic [CW-1:0]     out_cycle_q, out_cycle_d;
  logic [LP*Z-1:0]   out_index_q, out_index_d;

  logic              load_out;
  logic [CW-1:0]     next_cnt;
  logic [LPZ*Z-1:0]  row_sel;
  logic [LPZ-1:0]    row_off;
  logic [LP*Z-1:0]   lane_addr;

  // The output register itself holds the current cycle, so the next cycle is
  // derived from out_cycle_q rather than a separate counter.
  always_comb begin
    load_out = 1'b0;
    next_cnt = out_cycle_q;
    if (state_q == IDLE) begin
      if (bus.start && seeded_q) begin
        load_out = 1'b1;
        next_cnt = bus.dir ? CNT_LAST : '0;
      end
    end else if (out_valid_q && bus.out_ready && !out_last_q) begin
      load_out = 1'b1;
      next_cnt = dir_q ? (out_cycle_q - CW'(1)) : (out_cycle_q + CW'(1));
    end
  end

  assign row_off = next_cnt[LPZ-1:0];

  generate
    if (FO > 1) begin : g_sweep_sel
      assign row_sel = seed_q[next_cnt[CW-1:LPZ]];
    end else begin : g_single_sweep
      assign row_sel = seed_q[0];
    end
  endgenerate

  for (genvar i = 0; i < Z; i++) begin : g_lane
    interleaver_agen_lane #(
      .LPZ (LPZ),
      .LP  (LP),
      .Z   (Z),
      .IDX (i)
    ) u_lane (
      .seed    (row_sel[i*LPZ +: LPZ]),
      .row_off (row_off),
      .addr    (lane_addr[i*LP +: LP])
    );
  end

  // Abort is applied last so it overrides start, advance and the done pulse.
  always_comb begin
    state_d     = state_q;
    seed_d      = seed_q;
    ld_ptr_d    = ld_ptr_q;
    seeded_d    = seeded_q;
    dir_d       = dir_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    out_cycle_d = out_cycle_q;
    out_index_d = out_index_q;

    if (state_q == IDLE && bus.ld_valid) begin
      seed_d[ld_ptr_q] = bus.ld_data;
      if (ld_ptr_q == PTR_LAST) begin
        seeded_d = 1'b1;
        ld_ptr_d = '0;
      end else begin
        ld_ptr_d = ld_ptr_q + PW'(1);
      end
    end

    if (state_q == IDLE && bus.start && seeded_q) begin
      state_d = RUN;
      dir_d   = bus.dir;
    end

    if (state_q == RUN && out_valid_q && bus.out_ready && out_last_q) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      done_d      = 1'b1;
    end

    if (load_out) begin
      out_valid_d = 1'b1;
      out_cycle_d = next_cnt;
      out_index_d = lane_addr;
      out_last_d  = dir_d ? (next_cnt == '0) : (next_cnt == CNT_LAST);
    end

    if (bus.abort) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      seed_q      <= '{default: '0};
      ld_ptr_q    <= '0;
      seeded_q    <= 1'b0;
      dir_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      out_cycle_q <= '0;
      out_index_q <= '0;
    end else begin
      state_q     <= state_d;
      seed_q      <= seed_d;
      ld_ptr_q    <= ld_ptr_d;
      seeded_q    <= seeded_d;
      dir_q       <= dir_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      out_cycle_q <= out_cycle_d;
      out_index_q <= out_index_d;
    end
  end

  assign bus.ld_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q == RUN);
  assign bus.seeded    = seeded_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_cycle = out_cycle_q;
  assign bus.out_index = out_index_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_interleaver_agen.sv
// Self-checking bench for interleaver_agen (FO=2, P=32, Z=8).
module tb_interleaver_agen;

  localparam int FO   = 2;
  localparam int P    = 32;
  localparam int Z    = 8;
  localparam int LPZ  = 2;
  localparam int LP   = 5;
  localparam int CW   = 3;
  localparam int NCYC = 8;

  typedef struct {
    bit              d;
    int              cyc;
    logic [LP*Z-1:0] idx;
  } known_t;

  logic clk;
  logic reset;

  int total;
  int bad;

  logic [15:0] tb_seed [FO];
  int          tb_ptr;
  bit          tb_seeded;
  bit          use_known;
  known_t      known [4];

  interleaver_agen_if #(.FO(FO), .P(P), .Z(Z)) bus ();

  interleaver_agen #(.FO(FO), .P(P), .Z(Z)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit st, input bit d, input bit ab, input bit lv,
                               input logic [15:0] ld, input bit rdy);
    bus.start     = st;
    bus.dir       = d;
    bus.abort     = ab;
    bus.ld_valid  = lv;
    bus.ld_data   = ld;
    bus.out_ready = rdy;
  endtask

  // Reference: sweep = c / (P/Z), offset = c % (P/Z); lane i address is the
  // rotated seed times Z plus i.
  function automatic logic [LP*Z-1:0] model(input int c);
    logic [LP*Z-1:0] res;
    int s;
    int r;
    int sd;
    int a;
    res = '0;
    s = c / (P / Z);
    r = c % (P / Z);
    for (int i = 0; i < Z; i++) begin
      sd = (int'(tb_seed[s]) >> (i * LPZ)) & ((1 << LPZ) - 1);
      a  = ((sd + r) % (P / Z)) * Z + i;
      res[i*LP +: LP] = a[LP-1:0];
    end
    return res;
  endfunction

  function automatic logic [LP*Z-1:0] packIdx(input int a0, input int a1, input int a2, input int a3,
                                              input int a4, input int a5, input int a6, input int a7);
    logic [LP*Z-1:0] res;
    res = {a7[LP-1:0], a6[LP-1:0], a5[LP-1:0], a4[LP-1:0],
           a3[LP-1:0], a2[LP-1:0], a1[LP-1:0], a0[LP-1:0]};
    return res;
  endfunction

  task automatic loadRow(input logic [15:0] data);
    bus.ld_valid = 1'b1;
    bus.ld_data  = data;
    checkOutput("ld_ready_idle", bus.ld_ready, 1);
    @(posedge clk); #1;
    bus.ld_valid = 1'b0;
    tb_seed[tb_ptr] = data;
    if (tb_ptr == FO - 1) begin
      tb_ptr = 0;
      tb_seeded = 1'b1;
    end else begin
      tb_ptr++;
    end
    checkOutput("seeded", bus.seeded, tb_seeded);
  endtask

  task automatic startIgnored(input string name);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checkOutput({name, "_valid"}, bus.out_valid, 0);
    checkOutput({name, "_busy"}, bus.busy, 0);
    @(posedge clk); #1;
    checkOutput({name, "_valid2"}, bus.out_valid, 0);
  endtask

  // mode 0: ready always high, 1: random ready, 2: 5-cycle stall at step 3.
  task automatic runWalk(input bit d, input int mode, input int abort_at, input bit ld_junk);
    int k;
    int stall;
    int exp_c;
    bit fin;
    bit aborting;
    bit rdy;
    bit prev_valid;
    bit prev_acc;
    bit prev_last;
    logic [LP*Z-1:0] prev_idx;
    logic [CW-1:0]   prev_cyc;
    k = 0; stall = 0; fin = 0; aborting = 0;
    prev_valid = 0; prev_acc = 0; prev_last = 0;
    prev_idx = '0; prev_cyc = '0;
    bus.dir   = d;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checkOutput("first_valid", bus.out_valid, 1);
    for (int t = 0; t < 400 && !fin; t++) begin
      if (aborting) begin
        checkOutput("abort_valid", bus.out_valid, 0);
        checkOutput("abort_done", bus.done, 0);
        checkOutput("abort_busy", bus.busy, 0);
        checkOutput("abort_ld_ready", bus.ld_ready, 1);
        bus.abort = 1'b0;
        fin = 1;
      end else if (prev_acc && prev_last) begin
        checkOutput("done_pulse", bus.done, 1);
        checkOutput("end_valid", bus.out_valid, 0);
        checkOutput("end_busy", bus.busy, 0);
        fin = 1;
      end else begin
        checkOutput("busy_run", bus.busy, 1);
        checkOutput("done_low", bus.done, 0);
        checkOutput("valid_run", bus.out_valid, 1);
        if (ld_junk) checkOutput("ld_ready_run", bus.ld_ready, 0);
        if (prev_valid && !prev_acc) begin
          checkOutput("hold_index", bus.out_index, prev_idx);
          checkOutput("hold_cycle", bus.out_cycle, prev_cyc);
        end
        exp_c = d ? (NCYC - 1 - k) : k;
        checkOutput("out_cycle", bus.out_cycle, exp_c);
        checkOutput("out_index", bus.out_index, model(exp_c));
        checkOutput("out_last", bus.out_last, (k == NCYC - 1));
        if (use_known) begin
          for (int e = 0; e < 4; e++) begin
            if (known[e].d == d && known[e].cyc == exp_c)
              checkOutput("known_vector", bus.out_index, known[e].idx);
          end
        end
        case (mode)
          1:       rdy = 1'($urandom_range(0, 1));
          2:       begin
                     if (k == 3 && stall < 5) begin
                       rdy = 1'b0;
                       stall++;
                     end else begin
                       rdy = 1'b1;
                     end
                   end
          default: rdy = 1'b1;
        endcase
        if (k == abort_at) begin
          bus.abort = 1'b1;
          rdy = 1'b1;
          aborting = 1;
        end
        bus.out_ready = rdy;
        prev_valid = bus.out_valid;
        prev_acc   = rdy;
        prev_last  = bus.out_last;
        prev_idx   = bus.out_index;
        prev_cyc   = bus.out_cycle;
        if (rdy) k++;
        if (ld_junk) begin
          bus.ld_valid = 1'b1;
          bus.ld_data  = 16'($urandom);
        end
      end
      if (!fin) begin
        @(posedge clk); #1;
      end
    end
    checkOutput("walk_timeout", fin, 1);
    bus.ld_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.abort     = 1'b0;
    @(posedge clk); #1;
    checkOutput("done_one_cycle", bus.done, 0);
    checkOutput("idle_after", bus.busy, 0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    tb_ptr = 0;
    tb_seeded = 0;
    use_known = 0;
    for (int i = 0; i < FO; i++) tb_seed[i] = '0;

    known[0] = '{d: 1'b0, cyc: 0, idx: packIdx(8, 25, 18, 3, 4, 21, 14, 31)};
    known[1] = '{d: 1'b0, cyc: 1, idx: packIdx(16, 1, 26, 11, 12, 29, 22, 7)};
    known[2] = '{d: 1'b0, cyc: 7, idx: packIdx(8, 25, 18, 3, 20, 5, 30, 15)};
    known[3] = '{d: 1'b1, cyc: 7, idx: packIdx(8, 25, 18, 3, 20, 5, 30, 15)};

    applyStimulus(0, 0, 0, 0, 16'h0, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", bus.out_valid, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_seeded", bus.seeded, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_last", bus.out_last, 0);
    checkOutput("rst_index", bus.out_index, 0);
    checkOutput("rst_cycle", bus.out_cycle, 0);
    checkOutput("rst_ld_ready", bus.ld_ready, 1);
    reset = 1'b0;
    @(posedge clk); #1;

    $display("[TB] start without seeds");
    startIgnored("noseed");
    loadRow(16'hD82D);
    startIgnored("halfseed");
    loadRow(16'h8772);

    $display("[TB] known vectors forward and reverse");
    use_known = 1;
    runWalk(1'b0, 0, -1, 1'b0);
    runWalk(1'b1, 0, -1, 1'b1);
    use_known = 0;

    $display("[TB] stall mid-walk");
    runWalk(1'b0, 2, -1, 1'b0);
    runWalk(1'b1, 2, -1, 1'b0);

    $display("[TB] abort and restart");
    runWalk(1'b0, 0, 3, 1'b0);
    use_known = 1;
    runWalk(1'b0, 0, -1, 1'b0);
    use_known = 0;

    $display("[TB] random seeds and backpressure");
    for (int n = 0; n < 6; n++) begin
      loadRow(16'($urandom));
      if ($urandom_range(0, 1) == 1) loadRow(16'($urandom));
      runWalk(1'($urandom_range(0, 1)), 1, -1, 1'($urandom_range(0, 1)));
    end

    $display("[TB] reset mid-walk");
    bus.dir = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_valid", bus.out_valid, 0);
    checkOutput("mid_rst_busy", bus.busy, 0);
    checkOutput("mid_rst_seeded", bus.seeded, 0);
    checkOutput("mid_rst_index", bus.out_index, 0);
    checkOutput("mid_rst_cycle", bus.out_cycle, 0);
    checkOutput("mid_rst_last", bus.out_last, 0);
    checkOutput("mid_rst_done", bus.done, 0);
    tb_ptr = 0;
    tb_seeded = 0;
    for (int i = 0; i < FO; i++) tb_seed[i] = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    startIgnored("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
